// File: rtl/xrnic_cm_pkt_parser_if.sv
// RX AXI-Stream bundle feeding the CM MAD parser.
// No tready: the sink consumes every valid beat.
interface xrnic_cm_pkt_parser_if #(
    parameter int DW = 512
);
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic            tvalid;
    logic            tlast;

    modport master (output tdata, tkeep, tvalid, tlast);
    modport slave  (input  tdata, tkeep, tvalid, tlast);
endinterface

// File: rtl/xrnic_cm_pkt_parser.sv
// Receive-side CM MAD parser: filters RoCEv2 UD SEND_ONLY to QP1,
// latches ConnectRequest/Reply/ReadyToUse fields, pulses per frame.
module xrnic_cm_pkt_parser #(
    parameter int          C_AXIS_DATA_WIDTH = 512,
    parameter logic [15:0] ATTR_REQ          = 16'h0010,
    parameter logic [15:0] ATTR_REP          = 16'h0013,
    parameter logic [15:0] ATTR_RTU          = 16'h0014
) (
    input  logic                        core_clk,
    input  logic                        core_aresetn,
    xrnic_cm_pkt_parser_if.slave        rx_s_axis,
    input  logic [31:0]                 local_ip,
    output logic [47:0]                 recv_CM_src_mac,
    output logic [31:0]                 recv_CM_src_ip,
    output logic [63:0]                 recv_MAD_Transaction_ID,
    output logic [15:0]                 recv_MAD_Attribute_ID,
    output logic [31:0]                 recv_CM_local_Comm_ID,
    output logic [31:0]                 recv_CM_remote_Comm_ID,
    output logic [63:0]                 recv_CM_loacl_CA_GUID,
    output logic [31:0]                 recv_CM_Q_KEY,
    output logic [23:0]                 recv_CM_QPN,
    output logic [23:0]                 recv_CM_start_PSN,
    output logic                        CM_Req_rcvd,
    output logic                        CM_Reply_rcvd,
    output logic                        CM_ReadyToUse_rcvd,
    output logic                        CM_pkt_drop
);

    localparam int NB = C_AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_BEAT0,
        S_BEAT1,
        S_BEAT2,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic        fail;
        logic        cand;
        logic [47:0] mac;
        logic [31:0] ip;
        logic [63:0] tid;
        logic [15:0] attr;
        logic [31:0] lid;
        logic [31:0] rid;
        logic [63:0] guid;
        logic [31:0] qkey;
        logic [23:0] qpn;
        logic [23:0] psn;
    } shadow_t;

    state_t          state;
    state_t          state_nxt;
    shadow_t         sh;
    shadow_t         sh_nxt;
    logic [NB-1:0][7:0] byt;
    logic            port_qp;
    logic            hdr_ok;
    logic [15:0]     b1_attr;
    logic            accept;
    logic            drop;
    logic            long_ok;
    logic            attr_ok;
    logic            unused_ok;

    // byt[i] is wire byte (64*beat + i) of the current beat
    assign byt = rx_s_axis.tdata;
    assign unused_ok = ^{byt, rx_s_axis.tkeep};

    assign port_qp = ({byt[36], byt[37]} == 16'h12B7) &&
                     ({byt[47], byt[48], byt[49]} == 24'h000001);

    assign hdr_ok = port_qp &&
                    ({byt[12], byt[13]} == 16'h0800) &&
                    (byt[23] == 8'h11) &&
                    ({byt[30], byt[31], byt[32], byt[33]} == local_ip) &&
                    (byt[42] == 8'h64) &&
                    (byt[62] == 8'h01) &&
                    (byt[63] == 8'h07);

    assign b1_attr = {byt[14], byt[15]};

    // State register
    always_ff @(posedge core_clk or negedge core_aresetn) begin
        if (!core_aresetn) state <= S_BEAT0;
        else               state <= state_nxt;
    end

    // Next state, shadow capture and commit decision for the current beat
    always_comb begin
        state_nxt = state;
        sh_nxt    = sh;
        accept    = 1'b0;
        drop      = 1'b0;
        long_ok   = 1'b0;
        attr_ok   = 1'b0;
        if (rx_s_axis.tvalid) begin
            unique case (state)
                S_BEAT0: begin
                    sh_nxt.fail = !hdr_ok;
                    sh_nxt.cand = port_qp;
                    sh_nxt.mac  = {byt[6], byt[7], byt[8],
                                   byt[9], byt[10], byt[11]};
                    sh_nxt.ip   = {byt[26], byt[27], byt[28], byt[29]};
                    state_nxt   = rx_s_axis.tlast ? S_BEAT0 : S_BEAT1;
                end
                S_BEAT1: begin
                    if (byt[0] != 8'h02 || byt[1] != 8'h03)
                        sh_nxt.fail = 1'b1;
                    sh_nxt.tid  = {byt[6], byt[7], byt[8], byt[9],
                                   byt[10], byt[11], byt[12], byt[13]};
                    sh_nxt.attr = b1_attr;
                    sh_nxt.lid  = {byt[22], byt[23], byt[24], byt[25]};
                    sh_nxt.guid = {byt[38], byt[39], byt[40], byt[41],
                                   byt[42], byt[43], byt[44], byt[45]};
                    if (b1_attr == ATTR_REQ)
                        sh_nxt.rid = '0;
                    else
                        sh_nxt.rid = {byt[26], byt[27], byt[28], byt[29]};
                    if (b1_attr == ATTR_REP) begin
                        sh_nxt.qkey = {byt[30], byt[31], byt[32], byt[33]};
                        sh_nxt.qpn  = {byt[34], byt[35], byt[36]};
                        sh_nxt.psn  = {byt[42], byt[43], byt[44]};
                    end else begin
                        sh_nxt.qkey = {byt[50], byt[51], byt[52], byt[53]};
                        sh_nxt.qpn  = {byt[54], byt[55], byt[56]};
                    end
                    state_nxt = rx_s_axis.tlast ? S_BEAT0 : S_BEAT2;
                end
                S_BEAT2: begin
                    if (sh.attr == ATTR_REQ)
                        sh_nxt.psn = {byt[2], byt[3], byt[4]};
                    state_nxt = rx_s_axis.tlast ? S_BEAT0 : S_DRAIN;
                end
                S_DRAIN: begin
                    state_nxt = rx_s_axis.tlast ? S_BEAT0 : S_DRAIN;
                end
            endcase
            if (rx_s_axis.tlast) begin
                // the frame must reach byte 132 (beat 2, lane 4)
                long_ok = (state == S_DRAIN) ||
                          (state == S_BEAT2 &&
                           rx_s_axis.tkeep[4:0] == 5'h1F);
                attr_ok = (sh_nxt.attr == ATTR_REQ) ||
                          (sh_nxt.attr == ATTR_REP) ||
                          (sh_nxt.attr == ATTR_RTU);
                accept  = !sh_nxt.fail && long_ok && attr_ok;
                drop    = sh_nxt.cand && !accept;
            end
        end
    end

    // Shadow registers follow every consumed beat
    always_ff @(posedge core_clk or negedge core_aresetn) begin
        if (!core_aresetn) sh <= '0;
        else if (rx_s_axis.tvalid) sh <= sh_nxt;
    end

    // Commit: pulses every cycle, field outputs only on accept
    always_ff @(posedge core_clk or negedge core_aresetn) begin
        if (!core_aresetn) begin
            recv_CM_src_mac         <= '0;
            recv_CM_src_ip          <= '0;
            recv_MAD_Transaction_ID <= '0;
            recv_MAD_Attribute_ID   <= '0;
            recv_CM_local_Comm_ID   <= '0;
            recv_CM_remote_Comm_ID  <= '0;
            recv_CM_loacl_CA_GUID   <= '0;
            recv_CM_Q_KEY           <= '0;
            recv_CM_QPN             <= '0;
            recv_CM_start_PSN       <= '0;
            CM_Req_rcvd             <= 1'b0;
            CM_Reply_rcvd           <= 1'b0;
            CM_ReadyToUse_rcvd      <= 1'b0;
            CM_pkt_drop             <= 1'b0;
        end else begin
            CM_Req_rcvd        <= accept && (sh_nxt.attr == ATTR_REQ);
            CM_Reply_rcvd      <= accept && (sh_nxt.attr == ATTR_REP);
            CM_ReadyToUse_rcvd <= accept && (sh_nxt.attr == ATTR_RTU);
            CM_pkt_drop        <= drop;
            if (accept) begin
                recv_CM_src_mac         <= sh_nxt.mac;
                recv_CM_src_ip          <= sh_nxt.ip;
                recv_MAD_Transaction_ID <= sh_nxt.tid;
                recv_MAD_Attribute_ID   <= sh_nxt.attr;
                recv_CM_local_Comm_ID   <= sh_nxt.lid;
                recv_CM_remote_Comm_ID  <= sh_nxt.rid;
                if (sh_nxt.attr == ATTR_REQ)
                    recv_CM_loacl_CA_GUID <= sh_nxt.guid;
                if (sh_nxt.attr != ATTR_RTU) begin
                    recv_CM_Q_KEY     <= sh_nxt.qkey;
                    recv_CM_QPN       <= sh_nxt.qpn;
                    recv_CM_start_PSN <= sh_nxt.psn;
                end
            end
        end
    end

endmodule

// File: tb/tb_xrnic_cm_pkt_parser.sv
// Testbench for xrnic_cm_pkt_parser: table vectors, reset corner,
// and randomized frames against a whole-frame reference model.
module tb_xrnic_cm_pkt_parser;

    localparam logic [15:0] A_REQ = 16'h0010;
    localparam logic [15:0] A_REP = 16'h0013;
    localparam logic [15:0] A_RTU = 16'h0014;
    localparam logic [31:0] LIP   = 32'hC0A80A0A;
    localparam logic [63:0] GUID0 = 64'h6CB31103_00880EB4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] local_ip = LIP;

    always #5 clk = ~clk;

    xrnic_cm_pkt_parser_if rx ();

    logic [47:0] o_mac;
    logic [31:0] o_ip;
    logic [63:0] o_tid;
    logic [15:0] o_attr;
    logic [31:0] o_lid;
    logic [31:0] o_rid;
    logic [63:0] o_guid;
    logic [31:0] o_qkey;
    logic [23:0] o_qpn;
    logic [23:0] o_psn;
    logic        p_req, p_rep, p_rtu, p_drop;

    xrnic_cm_pkt_parser dut (
        .core_clk                (clk),
        .core_aresetn            (rst_n),
        .rx_s_axis               (rx.slave),
        .local_ip                (local_ip),
        .recv_CM_src_mac         (o_mac),
        .recv_CM_src_ip          (o_ip),
        .recv_MAD_Transaction_ID (o_tid),
        .recv_MAD_Attribute_ID   (o_attr),
        .recv_CM_local_Comm_ID   (o_lid),
        .recv_CM_remote_Comm_ID  (o_rid),
        .recv_CM_loacl_CA_GUID   (o_guid),
        .recv_CM_Q_KEY           (o_qkey),
        .recv_CM_QPN             (o_qpn),
        .recv_CM_start_PSN       (o_psn),
        .CM_Req_rcvd             (p_req),
        .CM_Reply_rcvd           (p_rep),
        .CM_ReadyToUse_rcvd      (p_rtu),
        .CM_pkt_drop             (p_drop)
    );

    typedef struct packed {
        logic [47:0] mac;
        logic [31:0] ip;
        logic [63:0] tid;
        logic [15:0] attr;
        logic [31:0] lid;
        logic [31:0] rid;
        logic [63:0] guid;
        logic [31:0] qkey;
        logic [23:0] qpn;
        logic [23:0] psn;
    } fields_t;

    typedef struct {
        int      evt;
        fields_t st;
    } exp_rec_t;

    typedef struct {
        logic [15:0] attr;
        logic [7:0]  method;
        logic [7:0]  opc;
        logic [23:0] qp;
        logic [15:0] port;
        int          len;
        logic [63:0] tid;
        logic [31:0] lid;
        logic [31:0] rid;
        logic [63:0] guid;
        logic [31:0] qkey;
        logic [23:0] qpn;
        logic [23:0] psn;
        int          evt;
    } vec_t;

    fields_t    dut_st;
    logic [3:0] pul;
    assign dut_st = {o_mac, o_ip, o_tid, o_attr, o_lid,
                     o_rid, o_guid, o_qkey, o_qpn, o_psn};
    assign pul = {p_drop, p_rtu, p_rep, p_req};

    exp_rec_t q[$];
    fields_t  exp_st;
    exp_rec_t cur;
    logic     was_last;
    int       checks = 0;
    int       passes = 0;
    logic [7:0] fr [0:319];
    int       flen;

    task automatic chk(input string nm, input logic [399:0] act,
                       input logic [399:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [3:0] evt_pulse(input int e);
        case (e)
            1: return 4'b0001;
            2: return 4'b0010;
            3: return 4'b0100;
            4: return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [63:0] get(input int pos, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[55:0], fr[pos+i]};
        return v;
    endfunction

    task automatic put(input int pos, input int n, input logic [63:0] v);
        for (int i = 0; i < n; i++) fr[pos+i] = v[8*(n-1-i) +: 8];
    endtask

    // Whole-frame classification: 0 none, 1 REQ, 2 REP, 3 RTU, 4 drop
    function automatic int model_evt();
        logic        cand;
        logic        ok;
        logic [15:0] at;
        cand = get(36, 2) == 64'h12B7 && get(47, 3) == 64'h1;
        ok = cand && get(12, 2) == 64'h0800 && fr[23] == 8'h11 &&
             get(30, 4) == {32'h0, local_ip} && fr[42] == 8'h64 &&
             fr[62] == 8'h01 && fr[63] == 8'h07 &&
             fr[64] == 8'h02 && fr[65] == 8'h03;
        at = get(78, 2);
        if (ok && flen >= 133 && (at == A_REQ || at == A_REP || at == A_RTU))
            return (at == A_REQ) ? 1 : (at == A_REP) ? 2 : 3;
        return cand ? 4 : 0;
    endfunction

    task automatic apply(input int e);
        if (e < 1 || e > 3) return;
        exp_st.mac  = get(6, 6);
        exp_st.ip   = get(26, 4);
        exp_st.tid  = get(70, 8);
        exp_st.attr = get(78, 2);
        exp_st.lid  = get(86, 4);
        if (e == 1) begin
            exp_st.rid  = '0;
            exp_st.guid = get(102, 8);
            exp_st.qkey = get(114, 4);
            exp_st.qpn  = get(118, 3);
            exp_st.psn  = get(130, 3);
        end else if (e == 2) begin
            exp_st.rid  = get(90, 4);
            exp_st.qkey = get(94, 4);
            exp_st.qpn  = get(98, 3);
            exp_st.psn  = get(106, 3);
        end else begin
            exp_st.rid  = get(90, 4);
        end
    endtask

    task automatic build(input vec_t v);
        flen = v.len;
        for (int i = 0; i < 320; i++) fr[i] = 8'($urandom);
        put(6, 6, {16'h000A, 32'($urandom)});
        put(12, 2, 64'h0800);
        fr[14] = 8'h45;
        fr[23] = 8'h11;
        put(26, 4, 64'($urandom));
        put(30, 4, {32'h0, LIP});
        put(36, 2, {48'h0, v.port});
        fr[42] = v.opc;
        put(47, 3, {40'h0, v.qp});
        fr[62] = 8'h01;
        fr[63] = 8'h07;
        fr[64] = 8'h02;
        fr[65] = v.method;
        put(70, 8, v.tid);
        put(78, 2, {48'h0, v.attr});
        put(86, 4, {32'h0, v.lid});
        if (v.attr == A_REP) begin
            put(90, 4, {32'h0, v.rid});
            put(94, 4, {32'h0, v.qkey});
            put(98, 3, {40'h0, v.qpn});
            put(106, 3, {40'h0, v.psn});
        end else if (v.attr == A_RTU) begin
            put(90, 4, {32'h0, v.rid});
        end else begin
            put(102, 8, v.guid);
            put(114, 4, {32'h0, v.qkey});
            put(118, 3, {40'h0, v.qpn});
            put(130, 3, {40'h0, v.psn});
        end
        for (int i = 0; i < 320; i++) if (i >= flen) fr[i] = 8'h00;
    endtask

    task automatic drive_beat(input int k, input logic last);
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            rx.tdata[8*i +: 8] = (64*k + i < flen) ? fr[64*k + i] : 8'h00;
            rx.tkeep[i] = (64*k + i < flen);
        end
        rx.tvalid = 1'b1;
        rx.tlast  = last;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx.tvalid = 1'b0;
            rx.tlast  = 1'b0;
        end
    endtask

    // force_evt < 0 lets the reference model classify the frame
    task automatic send(input int force_evt, input int gapmax);
        int nb;
        int e;
        nb = (flen + 63) / 64;
        for (int k = 0; k < nb; k++) begin
            drive_beat(k, k == nb - 1);
            if (k == nb - 1) begin
                e = (force_evt < 0) ? model_evt() : force_evt;
                apply(e);
                q.push_back('{evt: e, st: exp_st});
            end else if (gapmax > 0 && $urandom_range(0, 3) == 0) begin
                idle($urandom_range(1, gapmax));
            end
        end
    endtask

    // Checker: one cycle after each tlast beat, compare pulses and fields
    always @(posedge clk) begin
        was_last = rst_n && rx.tvalid && rx.tlast;
        #1;
        if (rst_n && was_last) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL queue: got empty expected entry");
            end else begin
                cur = q.pop_front();
                chk("pulse", 400'(pul), 400'(evt_pulse(cur.evt)));
                chk("fields", 400'(dut_st), 400'(cur.st));
            end
        end else if (rst_n) begin
            chk("idle_pulse", 400'(pul), 400'(0));
        end
    end

    vec_t tbl[10];
    vec_t rv;
    int   c;

    initial begin
        tbl[0] = '{A_REQ, 8'h03, 8'h64, 24'h1, 16'h12B7, 318,
                   64'h00000003D385012E, 32'h2E0185D3, 32'h0, GUID0,
                   32'h12345678, 24'h000002, 24'hAACFA8, 1};
        tbl[1] = '{A_REP, 8'h03, 8'h64, 24'h1, 16'h12B7, 318,
                   64'h00000003D3850200, 32'h44440003, 32'h2E0185D3,
                   64'h0, 32'h87654321, 24'h000002, 24'h123456, 2};
        tbl[2] = '{A_RTU, 8'h03, 8'h64, 24'h1, 16'h12B7, 318,
                   64'h00000003D3850201, 32'h2E0185D3, 32'h44440003,
                   64'h0, 32'h0, 24'h0, 24'h0, 3};
        tbl[3] = '{A_REQ, 8'h01, 8'h64, 24'h1, 16'h12B7, 318,
                   64'h11, 32'h1, 32'h0, 64'h77, 32'h5, 24'h6, 24'h7, 4};
        tbl[4] = '{16'h0015, 8'h03, 8'h64, 24'h1, 16'h12B7, 318,
                   64'h22, 32'h2, 32'h0, 64'h88, 32'h5, 24'h6, 24'h7, 4};
        tbl[5] = '{A_REQ, 8'h03, 8'h64, 24'h1, 16'h12B7, 100,
                   64'h33, 32'h3, 32'h0, 64'h99, 32'h5, 24'h6, 24'h7, 4};
        tbl[6] = '{A_REQ, 8'h03, 8'h0A, 24'h2, 16'h12B7, 318,
                   64'h44, 32'h4, 32'h0, 64'hAA, 32'h5, 24'h6, 24'h7, 0};
        tbl[7] = '{A_REQ, 8'h03, 8'h64, 24'h1, 16'h1234, 318,
                   64'h55, 32'h5, 32'h0, 64'hBB, 32'h5, 24'h6, 24'h7, 0};
        tbl[8] = '{A_REQ, 8'h03, 8'h64, 24'h1, 16'h12B7, 133,
                   64'h66, 32'h6, 32'h0, 64'hCC, 32'h9, 24'hA, 24'hB0B1B2, 1};
        tbl[9] = '{A_REQ, 8'h03, 8'h64, 24'h1, 16'h12B7, 132,
                   64'h77, 32'h7, 32'h0, 64'hDD, 32'h9, 24'hA, 24'hB, 4};

        rx.tdata  = '0;
        rx.tkeep  = '0;
        rx.tvalid = 1'b0;
        rx.tlast  = 1'b0;
        exp_st    = '0;
        #22;
        chk("reset", {pul, dut_st}, 400'(0));
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Test-plan vectors, all back-to-back
        for (int i = 0; i < 10; i++) begin
            build(tbl[i]);
            send(tbl[i].evt, 0);
        end
        idle(3);

        // Reset during beat 1 of a REQ, then a fresh REQ
        build(tbl[0]);
        drive_beat(0, 1'b0);
        drive_beat(1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid", {pul, dut_st}, 400'(0));
        idle(2);
        rst_n  = 1'b1;
        exp_st = '0;
        q.delete();
        build(tbl[0]);
        send(1, 0);
        idle(3);

        // Randomized frames with gaps, classified by the model
        for (int n = 0; n < 80; n++) begin
            rv = tbl[0];
            case ($urandom_range(0, 3))
                0: rv.attr = A_REQ;
                1: rv.attr = A_REP;
                2: rv.attr = A_RTU;
                default: rv.attr = 16'h0015;
            endcase
            case ($urandom_range(0, 5))
                0: rv.len = 318;
                1: rv.len = 133;
                2: rv.len = 132;
                3: rv.len = 128;
                4: rv.len = 100;
                default: rv.len = $urandom_range(64, 320);
            endcase
            rv.tid  = {$urandom, $urandom};
            rv.lid  = $urandom;
            rv.rid  = $urandom;
            rv.guid = {$urandom, $urandom};
            rv.qkey = $urandom;
            rv.qpn  = 24'($urandom);
            rv.psn  = 24'($urandom);
            build(rv);
            c = $urandom_range(0, 15);
            case (c)
                0: fr[13] ^= 8'h01;
                1: fr[23] ^= 8'h02;
                2: fr[33] ^= 8'h04;
                3: fr[37] ^= 8'h08;
                4: fr[42] ^= 8'h10;
                5: fr[49] ^= 8'h03;
                6: fr[62] ^= 8'h02;
                7: fr[63] ^= 8'h01;
                8: fr[64] ^= 8'h01;
                9: fr[65] ^= 8'h02;
                default: ;
            endcase
            for (int i = 0; i < 320; i++) if (i >= flen) fr[i] = 8'h00;
            send(-1, 3);
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end
        idle(4);
        chk("pending", 400'(q.size()), 400'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/xrnic_cm_pkt_parser.md
# xrnic_cm_pkt_parser

Receive-side Connection Manager (CM) MAD parser for the XRNIC datapath. It sits on the 512-bit RX AXI-Stream from the MAC, alongside the RoCE RX path, and inspects every frame. Each frame that is a RoCEv2 UD SEND_ONLY to QP1 carrying a CM MAD (ConnectRequest, ConnectReply or ReadyToUse) has its connection fields latched and a one-cycle indication pulsed. These outputs drive the CM handshake FSM and the reply fields of the CM packet generator (`recv_*`).

## Interface
- C_AXIS_DATA_WIDTH, 512, RX stream width; only 512 is supported.
- ATTR_REQ, 16'h0010, MAD Attribute ID for ConnectRequest.
- ATTR_REP, 16'h0013, MAD Attribute ID for ConnectReply.
- ATTR_RTU, 16'h0014, MAD Attribute ID for ReadyToUse.
- core_clk  in  1  core clock.
- core_aresetn  in  1  reset, asynchronous, active-low.
- rx_s_axis_tdata  in  512  frame data; wire byte n is at tdata[8*(n%64)+:8] of beat n/64.
- rx_s_axis_tkeep  in  64  byte enables; contiguous from bit 0.
- rx_s_axis_tvalid  in  1  beat valid. There is no tready; every valid beat is consumed.
- rx_s_axis_tlast  in  1  last beat of frame.
- local_ip  in  32  local IPv4 address; frames whose IPv4 destination differs are rejected.
- recv_CM_src_mac  out  48  Ethernet source MAC of the accepted frame.
- recv_CM_src_ip  out  32  IPv4 source address.
- recv_MAD_Transaction_ID  out  64  MAD transaction ID.
- recv_MAD_Attribute_ID  out  16  MAD attribute ID.
- recv_CM_local_Comm_ID  out  32  sender's local comm ID.
- recv_CM_remote_Comm_ID  out  32  remote comm ID; REP/RTU only, else 0.
- recv_CM_loacl_CA_GUID  out  64  sender CA GUID; REQ only, else unchanged.
- recv_CM_Q_KEY  out  32  sender local Q_Key; REQ/REP.
- recv_CM_QPN  out  24  sender local QPN; REQ/REP.
- recv_CM_start_PSN  out  24  sender starting PSN; REQ/REP.
- CM_Req_rcvd, CM_Reply_rcvd, CM_ReadyToUse_rcvd  out  1 each  one-cycle accept pulses.
- CM_pkt_drop  out  1  one-cycle pulse: frame looked like a CM MAD but failed a check.

## Operation
- Multi-byte fields are in network order: the first wire byte is the field MSB.
- Filter checks:
  - ethertype[12:13] = 0x0800
  - IP protocol[23] = 0x11
  - IP dst[30:33] = local_ip
  - UDP dst port[36:37] = 0x12B7
  - BTH opcode[42] = 0x64
  - BTH dest QP[47:49] = 0x000001
  - MAD base version[62] = 0x01
  - mgmt class[63] = 0x07
  - class version[64] = 0x02
  - method[65] = 0x03
- Captured fields, all formats: src MAC[6:11], src IP[26:29], transaction ID[70:77], attribute ID[78:79], local comm ID[86:89].
- REQ fields: CA GUID[102:109], Q_Key[114:117], QPN[118:120], start PSN[130:132].
- REP fields: remote comm ID[90:93], Q_Key[94:97], QPN[98:100], start PSN[106:108].
- RTU fields: remote comm ID[90:93].
- FSM:
  - S_BEAT0: on a valid beat, run the beat-0 checks and capture into shadow registers, then go to S_BEAT1. If tlast is set on this beat, the frame is too short: stay in S_BEAT0.
  - S_BEAT1: run the beat-1 checks and capture. Go to S_BEAT2, or to S_BEAT0 if tlast is set.
  - S_BEAT2: capture the REQ start PSN. If tlast is set, go to S_BEAT0; otherwise go to S_DRAIN.
  - S_DRAIN: discard beats until tlast, then go to S_BEAT0.
- Shadow registers: a sticky fail flag and a sticky "candidate" flag. Candidate is set when the UDP port and BTH dest QP both match.
- Commit at the tlast beat:
  - Accept when: not failed, the frame reached S_BEAT2, and the attribute ID is one of the three. The shadow values are copied to the outputs and the matching *_rcvd signal pulses.
  - Drop when: candidate and (failed, or short frame, or unknown attribute). CM_pkt_drop pulses and the outputs are not changed.
  - Non-candidate frames (ordinary RoCE or other traffic) are ignored silently.
- Short-frame rule: the frame must contain byte 132. If tlast arrives in S_BEAT2, tkeep[4:0] must be 5'h1F.
- On an RTU accept, the REQ/REP-only outputs keep their previous values. recv_CM_remote_Comm_ID is forced to 0 on a REQ accept.
- Only one of the four pulses is asserted in any cycle.
- Trailing FCS and padding beyond byte 132 are ignored.

## Timing
- Reset: every output is 0 and the FSM is in S_BEAT0. The asynchronous reset is applied mid-frame only together with the MAC RX reset, so the first beat after reset release is a frame start.
- Latency: pulses and output updates are registered and appear in the cycle after the tlast beat.
- Outputs hold their values until the next accept.
- Back-to-back frames: a tlast beat may be followed immediately by beat 0 of the next frame. Commit of frame N and capture of frame N+1 beat 0 happen in the same cycle without loss.
- tvalid low between beats holds the FSM state; gaps of any length are allowed.
- The 318-byte CM frame spans 5 beats (beats 0-4).

## Test plan
- REQ, local_ip=0xC0A80A0A, dst IP 0xC0A80A0A, transaction ID 0x00000003D385012E, local comm ID 0x2E0185D3, GUID 0x6CB31103_00880EB4, Q_Key 0x12345678, QPN 0x000002, PSN 0xAACFA8, 5 beats -> CM_Req_rcvd pulses 1 cycle after tlast; all fields match; remote comm ID 0.
- REP with local comm ID 0x44440003, remote comm ID 0x2E0185D3, QPN 0x000002, PSN 0x123456 -> CM_Reply_rcvd pulses with those values; GUID unchanged from the REQ test.
- RTU immediately back-to-back after the REP (no idle cycle) -> CM_Reply_rcvd pulses, then CM_ReadyToUse_rcvd pulses the next frame; Q_Key, QPN and PSN still hold the REP values.
- Candidate frames -> CM_pkt_drop pulses and the outputs are unchanged:
  - REQ with method 0x01
  - attribute 0x0015
  - frame ending at byte 100
- Plain RoCE WRITE (dest QP 0x000002) and UDP port 0x1234 frames -> no pulse of any kind.
- Reset asserted during beat 1 of a REQ, then a fresh REQ -> outputs 0 during reset; only the second REQ produces CM_Req_rcvd.
